// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer domains: Gray conversion,
// depth derivation and the full/empty pointer comparison.
package fifo_pkg;

  localparam int unsigned PTR_MAX = 32;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Pointers of width asz+1; full when the two MSBs differ and the rest match.
  function automatic logic full_match(input logic [PTR_MAX-1:0] wgray,
                                      input logic [PTR_MAX-1:0] rgray,
                                      input int unsigned        asz);
    logic [PTR_MAX-1:0] v_inv;
    v_inv          = '0;
    v_inv[asz]     = 1'b1;
    v_inv[asz-1]   = 1'b1;
    return wgray == (rgray ^ v_inv);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the rr pointer,
// wrapping; the pointer advances past the winner on every granted edge.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] r_rr;
  logic          w_found;

  always_comb begin
    int unsigned v_idx;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      v_idx = (32'(r_rr) + i) % NUM_REQ;
      if (!w_found && en && req[v_idx]) begin
        w_found      = 1'b1;
        gnt[v_idx]   = 1'b1;
        gnt_idx      = IW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_found) begin
      r_rr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: arbitrates producers onto the memory write
// port and maintains the binary/Gray write pointer and registered full flag.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 3,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic [ADDR_SIZE:0]           wq2_rptr,
  output logic                         wr_en,
  output logic [ADDR_SIZE-1:0]         waddr,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic [ADDR_SIZE:0]           wptr,
  output logic                         wfull
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_ptr;
  logic          r_full;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic          w_full_next;
  logic          w_arb_en;
  logic [IW-1:0] w_gnt_idx;

  // Gating with wrst_n kills any in-flight grant the instant reset asserts.
  assign w_arb_en = ~r_full & wrst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk     (wclk),
    .rst_n   (wrst_n),
    .req     (req),
    .en      (w_arb_en),
    .gnt     (gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign wr_en = |gnt;
  assign waddr = r_bin[ADDR_SIZE-1:0];
  assign wptr  = r_ptr;
  assign wfull = r_full;

  always_comb begin
    wdata = '0;
    if (wr_en) begin
      wdata = req_data[32'(w_gnt_idx)*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign w_bin_next  = r_bin + PW'(wr_en);
  assign w_gray_next = PW'(bin2gray(PTR_MAX'(w_bin_next)));
  assign w_full_next = full_match(PTR_MAX'(w_gray_next), PTR_MAX'(wq2_rptr), ADDR_SIZE);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_bin  <= '0;
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_ptr  <= w_gray_next;
      r_full <= w_full_next;
    end
  end

  a_gnt_onehot0: assert property (@(posedge wclk) disable iff (!wrst_n) $onehot0(gnt));
  a_no_wr_full:  assert property (@(posedge wclk) disable iff (!wrst_n) !(wr_en && wfull));
  a_gray_step:   assert property (@(posedge wclk) disable iff (!wrst_n)
                                  $countones(wptr ^ $past(wptr)) <= 1);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the shared FIFO memory: round-robin arbitration among NUM_REQ producers for the single memory write port.
- Generates wr_en, waddr and wdata for the memory.
- Maintains the binary/Gray write pointer and the registered full flag, using the read pointer already synchronised into the write domain.
- Sits in the wclk domain between the producers and the memory; the Gray pointer output feeds the read-domain synchroniser.

Parameters:
- ADDR_SIZE, 3, memory address width; depth = 2**ADDR_SIZE.
- DATA_SIZE, 8, data word width.
- NUM_REQ, 2, number of requesters (>=2).

Ports:
- wclk  input  1  write-domain clock; all state on posedge.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request; held until granted.
- req_data  input  NUM_REQ*DATA_SIZE  packed requester data; slice i = bits [i*DATA_SIZE +: DATA_SIZE]; stable while req[i] is high.
- gnt  output  NUM_REQ  one-hot grant; the word is written on this edge.
- wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already 2-flop synchronised into wclk.
- wr_en  output  1  memory write enable.
- waddr  output  ADDR_SIZE  memory write address.
- wdata  output  DATA_SIZE  memory write data (granted requester's slice).
- wptr  output  ADDR_SIZE+1  registered Gray write pointer.
- wfull  output  1  registered full flag.

Behaviour:
- Reset (async on wrst_n low, immediate):
  - wbin = 0, wptr = 0, wfull = 0, round-robin pointer rr = 0.
  - gnt = 0 and wr_en = 0 while wrst_n is low.
  - Reset takes effect mid-burst with no completion of the in-flight grant.
- Grant (combinational, same cycle):
  - If wfull = 1, gnt = 0.
  - Otherwise, grant the first asserted req scanning from index rr upward, wrapping modulo NUM_REQ.
  - gnt is one-hot or zero.
- Handshake:
  - A transfer completes on a posedge where req[i] and gnt[i] are both high.
  - The requester may drop req or change data only after that edge.
  - Zero-latency grant; no bubble between back-to-back writes.
- Memory interface:
  - wr_en = |gnt.
  - waddr = wbin[ADDR_SIZE-1:0].
  - wdata = req_data slice of the granted index; 0 when no grant.
- Pointer update on posedge:
  - winc = wr_en.
  - wbin_next = wbin + winc, modulo 2**(ADDR_SIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wbin <= wbin_next; wptr <= wgray_next.
- Full, registered:
  - wfull <= (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
  - The comparison is re-evaluated every cycle, so wfull clears one edge after wq2_rptr moves, even with no write.
- Round-robin pointer:
  - On a granted edge, rr <= (granted index + 1) mod NUM_REQ.
  - rr is unchanged when no grant occurs.
- Boundary cases:
  - Wrap-around: waddr wraps 2**ADDR_SIZE-1 -> 0; wptr wraps at 2**(ADDR_SIZE+1).
  - The write that fills the FIFO is accepted; no further grant is issued until wfull drops.
  - Requests arriving while full are held, not lost.
  - A single requester gets every cycle.
- Assertions:
  - gnt is one-hot or zero.
  - No wr_en while wfull.
  - wptr changes by at most 1 Gray bit per cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray function.
  - Depth localparam derivation.
  - Full-compare helper, so the read-side empty logic uses the same function.
- One sub-module: rr_arbiter (NUM_REQ; inputs req, en, clk/reset; outputs one-hot gnt; owns the rr pointer).
- The pointer/full logic stays in fifo_wr_arbiter.

Test Plan:
All scenarios use defaults ADDR_SIZE=3, NUM_REQ=2, depth 8.
- Reset: assert wrst_n=0 mid-stream with req=2'b11 -> gnt=0, wr_en=0, wptr=4'b0000, wfull=0 immediately, without waiting for a clock edge.
- Single requester fill:
  - Stimulus: req=2'b01, wq2_rptr=0, data 0x10..0x17.
  - Writes land at waddr 0..7.
  - After the 8th edge: wptr=4'b1100, wfull=1, gnt=0.
  - A 9th req is held with no write.
- Fairness: req=2'b11 continuous after reset, wq2_rptr tracking -> gnt sequence 01,10,01,10; wdata alternates between the two slices.
- Un-full: from the full state (wptr=1100), set wq2_rptr=4'b0001 -> wfull=0 after the next edge; next cycle gnt[0]=1, waddr=0.
- Wrap:
  - 16 writes with wq2_rptr kept 2 behind.
  - Required: waddr sequence 0..7,0..7; wptr returns to 4'b0000; wfull never asserts.
- Late requester: req[1] rises while req[0] is being serviced and rr=1 -> req[1] is granted on the next cycle, req[0] waits one cycle.
